// File: rtl/control_pipe.sv
// control_pipe: carries decoded EX/MEM/WB control bundles down the
// ID/EX -> EX/MEM -> MEM/WB registers. It also detects load-use hazards,
// inserts bubbles, and drives the front-end stall/flush controls.
// Optional feature macro: CTRL_PIPE_CNT_EN enables the saturating bubble counter.
module control_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_ex,
  input  logic [2:0]       id_mem,
  input  logic [1:0]       id_wb,
  input  logic             id_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             br_taken,
  output logic [3:0]       ex_ctrl,
  output logic [2:0]       ex_mem_fwd,
  output logic [2:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic [REG_W-1:0] ex_rt,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             if_flush,
  output logic [CNT_W-1:0] bubble_cnt
);

  // ID/EX stage registers
  logic [3:0]       ex_p0;
  logic [2:0]       mem_p0;
  logic [1:0]       wb_p0;
  logic [REG_W-1:0] rt_p0;
  // EX/MEM stage registers
  logic [2:0]       mem_p1;
  logic [1:0]       wb_p1;
  // MEM/WB stage register
  logic [1:0]       wb_p2;

  logic             bubble;

  // Load-use hazard: the instruction in EX is a load whose destination
  // is read by the instruction in ID. Register 0 never creates a dependency.
  always_comb begin
    stall = mem_p0[1] & (rt_p0 != '0) & ((rt_p0 == id_rs) | (rt_p0 == id_rt));
    bubble     = br_taken | stall;
    pc_write   = ~stall;
    ifid_write = ~stall;
    // A jump waiting behind a stall is flushed only once it is finally decoded.
    if_flush   = br_taken | (id_jump & ~stall);
  end

  // ID/EX load: reset > bubble (branch flush or load-use stall) > normal
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_p0  <= '0;
      mem_p0 <= '0;
      wb_p0  <= '0;
      rt_p0  <= '0;
    end else if (bubble) begin
      ex_p0  <= '0;
      mem_p0 <= '0;
      wb_p0  <= '0;
      rt_p0  <= '0;
    end else begin
      ex_p0  <= id_ex;
      mem_p0 <= id_mem;
      wb_p0  <= id_wb;
      rt_p0  <= id_rt;
    end
  end

  // EX/MEM and MEM/WB advance every cycle; they are never stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_p1 <= '0;
      wb_p1  <= '0;
      wb_p2  <= '0;
    end else begin
      mem_p1 <= mem_p0;
      wb_p1  <= wb_p0;
      wb_p2  <= wb_p1;
    end
  end

`ifdef CTRL_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count every bubble loaded into ID/EX, holding at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bubble && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

  assign ex_ctrl    = ex_p0;
  assign ex_mem_fwd = mem_p0;
  assign ex_rt      = rt_p0;
  assign mem_ctrl   = mem_p1;
  assign wb_ctrl    = wb_p2;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: reset state, stage latency, load-use
// stall, jump/branch flush interaction, bubble propagation, mid-run reset.
module tb_control_pipe;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       id_ex;
  logic [2:0]       id_mem;
  logic [1:0]       id_wb;
  logic             id_jump;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             br_taken;
  logic [3:0]       ex_ctrl;
  logic [2:0]       ex_mem_fwd;
  logic [2:0]       mem_ctrl;
  logic [1:0]       wb_ctrl;
  logic [REG_W-1:0] ex_rt;
  logic             stall;
  logic             pc_write;
  logic             ifid_write;
  logic             if_flush;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

`ifdef CTRL_PIPE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  control_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_ex      (id_ex),
    .id_mem     (id_mem),
    .id_wb      (id_wb),
    .id_jump    (id_jump),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .br_taken   (br_taken),
    .ex_ctrl    (ex_ctrl),
    .ex_mem_fwd (ex_mem_fwd),
    .mem_ctrl   (mem_ctrl),
    .wb_ctrl    (wb_ctrl),
    .ex_rt      (ex_rt),
    .stall      (stall),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .if_flush   (if_flush),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then observed at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic jmp, input logic br);
    id_ex = ex; id_mem = mem; id_wb = wb; id_rs = rs; id_rt = rt;
    id_jump = jmp; br_taken = br;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0000, 3'b000, 2'b10, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    // 1: reset state
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst_mem_ctrl", 32'(mem_ctrl), 32'h0);
    chk("rst_wb_ctrl", 32'(wb_ctrl), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_pc_write", 32'(pc_write), 32'h1);
    chk("rst_ifid_write", 32'(ifid_write), 32'h1);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'h0);
    drive(4'b0000, 3'b000, 2'b10, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("rst_if_flush_jump", 32'(if_flush), 32'h1);

    // 2: R-type latency
    reset = 1'b0;
    drive(4'b1100, 3'b000, 2'b10, 5'd2, 5'd3, 1'b0, 1'b0);
    step();
    chk("r_ex_ctrl_n1", 32'(ex_ctrl), 32'hC);
    chk("r_ex_rt_n1", 32'(ex_rt), 32'h3);
    chk("r_wb_ctrl_n1", 32'(wb_ctrl), 32'h0);
    drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk("r_ex_ctrl_n2", 32'(ex_ctrl), 32'h0);
    chk("r_wb_ctrl_n2", 32'(wb_ctrl), 32'h0);
    step();
    chk("r_wb_ctrl_n3", 32'(wb_ctrl), 32'h2);
    step();
    chk("r_wb_ctrl_n4", 32'(wb_ctrl), 32'h0);

    // sw: MEM field latency
    drive(4'b0001, 3'b001, 2'b00, 5'd1, 5'd2, 1'b0, 1'b0);
    step();
    chk("sw_ex_mem_fwd", 32'(ex_mem_fwd), 32'h1);
    chk("sw_mem_ctrl_n1", 32'(mem_ctrl), 32'h0);
    drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk("sw_mem_ctrl_n2", 32'(mem_ctrl), 32'h1);
    step();
    chk("sw_mem_ctrl_n3", 32'(mem_ctrl), 32'h0);

    // 3: lw rt=5 then add rs=5
    drive(4'b0001, 3'b010, 2'b11, 5'd0, 5'd5, 1'b0, 1'b0);
    step();
    chk("lw_ex_mem_fwd", 32'(ex_mem_fwd), 32'h2);
    drive(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 1'b0, 1'b0);
    chk("lu_stall", 32'(stall), 32'h1);
    chk("lu_pc_write", 32'(pc_write), 32'h0);
    chk("lu_ifid_write", 32'(ifid_write), 32'h0);
    chk("lu_if_flush", 32'(if_flush), 32'h0);
    step();
    chk("lu_bubble_ex", 32'(ex_ctrl), 32'h0);
    chk("lu_bubble_rt", 32'(ex_rt), 32'h0);
    chk("lu_stall_clear", 32'(stall), 32'h0);
    chk("lu_pc_write_back", 32'(pc_write), 32'h1);
    chk("lu_lw_mem_ctrl", 32'(mem_ctrl), 32'h2);
    chk("lu_bubble_cnt", 32'(bubble_cnt), CNT_ON ? 32'h1 : 32'h0);
    step();
    chk("lu_add_ex", 32'(ex_ctrl), 32'hC);
    chk("lu_add_rt", 32'(ex_rt), 32'h6);
    chk("lu_lw_wb", 32'(wb_ctrl), 32'h3);
    drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk("lu_bubble_wb", 32'(wb_ctrl), 32'h0);

    // 4: lw rt=0 then use of r0
    drive(4'b0001, 3'b010, 2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(4'b1100, 3'b000, 2'b10, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("r0_no_stall", 32'(stall), 32'h0);
    chk("r0_pc_write", 32'(pc_write), 32'h1);
    step();

    // 5: jump without and with load-use hazard
    drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("jmp_flush", 32'(if_flush), 32'h1);
    drive(4'b0001, 3'b010, 2'b11, 5'd0, 5'd7, 1'b0, 1'b0);
    step();
    drive(4'b0000, 3'b000, 2'b00, 5'd7, 5'd0, 1'b1, 1'b0);
    chk("jmp_hz_stall", 32'(stall), 32'h1);
    chk("jmp_hz_no_flush", 32'(if_flush), 32'h0);
    step();
    chk("jmp_hz_released", 32'(stall), 32'h0);
    chk("jmp_hz_flush", 32'(if_flush), 32'h1);
    chk("jmp_bubble_cnt", 32'(bubble_cnt), CNT_ON ? 32'h2 : 32'h0);

    // 6: branch taken coinciding with a stall, sw in ID
    drive(4'b0001, 3'b010, 2'b11, 5'd0, 5'd9, 1'b0, 1'b0);
    step();
    drive(4'b0001, 3'b001, 2'b00, 5'd1, 5'd9, 1'b0, 1'b1);
    chk("br_st_stall", 32'(stall), 32'h1);
    chk("br_st_flush", 32'(if_flush), 32'h1);
    step();
    chk("br_st_ex", 32'(ex_ctrl), 32'h0);
    chk("br_st_fwd", 32'(ex_mem_fwd), 32'h0);
    chk("br_st_cnt", 32'(bubble_cnt), CNT_ON ? 32'h3 : 32'h0);
    drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk("br_st_mem_ctrl", 32'(mem_ctrl), 32'h0);

    // branch alone squashes a valid sw
    drive(4'b0001, 3'b001, 2'b00, 5'd1, 5'd2, 1'b0, 1'b1);
    chk("br_flush", 32'(if_flush), 32'h1);
    step();
    chk("br_fwd", 32'(ex_mem_fwd), 32'h0);

    // 7: reset mid-operation
    drive(4'b0001, 3'b010, 2'b11, 5'd0, 5'd4, 1'b0, 1'b0);
    step();
    drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk("mid_mem_before", 32'(mem_ctrl), 32'h2);
    reset = 1'b1;
    drive(4'b1100, 3'b010, 2'b11, 5'd0, 5'd4, 1'b0, 1'b0);
    step();
    chk("mid_ex", 32'(ex_ctrl), 32'h0);
    chk("mid_mem", 32'(mem_ctrl), 32'h0);
    chk("mid_wb", 32'(wb_ctrl), 32'h0);
    chk("mid_cnt", 32'(bubble_cnt), 32'h0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
